// File: rtl/cdc_xfer_arb.sv
`timescale 1ns/1ps
// cdc_xfer_arb: round-robin arbiter feeding a toggle-handshake clk1 -> clk2 multi-bit transfer.
// Define CDC_XFER_STATS_EN to build the saturating completed-transfer counter on xfer_cnt_o.
//
// state      | meaning
// S_IDLE     | nothing in flight; the round-robin winner is granted combinationally
// S_WAIT_ACK | hold_data/hold_src frozen for clk2; wait for the ack toggle to match req toggle
module cdc_xfer_arb #(
    parameter int NREQ        = 4,
    parameter int DW          = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                     clk1,
    input  logic                     clk2,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req_valid_i,
    input  logic [NREQ*DW-1:0]       req_data_i,
    output logic [NREQ-1:0]          req_ready_o,
    output logic                     busy_o,
    output logic                     out_valid_o,
    output logic [DW-1:0]            out_data_o,
    output logic [$clog2(NREQ)-1:0]  out_src_o,
    output logic [15:0]              xfer_cnt_o
);

    localparam int IW = $clog2(NREQ);

    typedef enum logic {S_IDLE = 1'b0, S_WAIT_ACK = 1'b1} state_t;

    state_t                 state_q, state_d;
    logic [IW-1:0]          rr_ptr_q, rr_ptr_d;
    logic [DW-1:0]          hold_data_q, hold_data_d;
    logic [IW-1:0]          hold_src_q, hold_src_d;
    logic                   req_tog_q, req_tog_d;
    logic [SYNC_STAGES-1:0] ack_sync_q;
    logic                   ack_sync;

    logic                   win_found;
    logic [IW-1:0]          win_idx;
    logic [DW-1:0]          win_data;
    logic                   accept;
    logic [IW:0]            search_sum;
    logic [IW-1:0]          search_idx;

    logic [SYNC_STAGES-1:0] req_sync_q;
    logic                   req_seen_q;
    logic                   req_new;
    logic                   ack_tog_q;
    logic                   out_valid_q;
    logic [DW-1:0]          out_data_q;
    logic [IW-1:0]          out_src_q;

    // Search upward from rr_ptr, wrapping at NREQ (which need not be a power of two).
    always_comb begin
        win_found  = 1'b0;
        win_idx    = '0;
        search_sum = '0;
        search_idx = '0;
        for (int k = 0; k < NREQ; k++) begin
            search_sum = {1'b0, rr_ptr_q} + (IW+1)'(k);
            if (search_sum >= (IW+1)'(NREQ)) begin
                search_sum = search_sum - (IW+1)'(NREQ);
            end
            search_idx = search_sum[IW-1:0];
            if (!win_found && req_valid_i[search_idx]) begin
                win_found = 1'b1;
                win_idx   = search_idx;
            end
        end
    end

    always_comb begin
        win_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win_idx == IW'(i)) begin
                win_data = req_data_i[i*DW +: DW];
            end
        end
    end

    assign accept   = (state_q == S_IDLE) && win_found;
    assign ack_sync = ack_sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            rr_ptr_q    <= '0;
            hold_data_q <= '0;
            hold_src_q  <= '0;
            req_tog_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            hold_data_q <= hold_data_d;
            hold_src_q  <= hold_src_d;
            req_tog_q   <= req_tog_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        hold_data_d = hold_data_q;
        hold_src_d  = hold_src_q;
        req_tog_d   = req_tog_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d     = S_WAIT_ACK;
                    hold_data_d = win_data;
                    hold_src_d  = win_idx;
                    req_tog_d   = ~req_tog_q;
                    rr_ptr_d    = (win_idx == IW'(NREQ-1)) ? '0 : win_idx + 1'b1;
                end
            end
            S_WAIT_ACK: begin
                if (ack_sync == req_tog_q) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready_o = '0;
        busy_o      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (win_found) begin
                    req_ready_o = NREQ'(1) << win_idx;
                end
            end
            S_WAIT_ACK: busy_o = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            ack_sync_q <= '0;
        end else begin
            ack_sync_q <= {ack_sync_q[SYNC_STAGES-2:0], ack_tog_q};
        end
    end

    // clk2 side: hold_data_q/hold_src_q are only sampled once the toggle has settled.
    assign req_new = req_sync_q[SYNC_STAGES-1] ^ req_seen_q;

    always_ff @(posedge clk2 or posedge rst) begin
        if (rst) begin
            req_sync_q  <= '0;
            req_seen_q  <= 1'b0;
            ack_tog_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_src_q   <= '0;
        end else begin
            req_sync_q  <= {req_sync_q[SYNC_STAGES-2:0], req_tog_q};
            req_seen_q  <= req_sync_q[SYNC_STAGES-1];
            out_valid_q <= req_new;
            if (req_new) begin
                out_data_q <= hold_data_q;
                out_src_q  <= hold_src_q;
                ack_tog_q  <= ~ack_tog_q;
            end
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign out_src_o   = out_src_q;

`ifdef CDC_XFER_STATS_EN
    logic [15:0] xfer_cnt_q;

    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            xfer_cnt_q <= '0;
        end else if ((state_q == S_WAIT_ACK) && (state_d == S_IDLE) && (xfer_cnt_q != 16'hFFFF)) begin
            xfer_cnt_q <= xfer_cnt_q + 16'd1;
        end
    end

    assign xfer_cnt_o = xfer_cnt_q;
`else
    assign xfer_cnt_o = 16'h0000;
`endif

endmodule

// File: tb/tb_cdc_xfer_arb.sv
`timescale 1ns/1ps
// tb_cdc_xfer_arb: directed vector table, multi-cycle corner sequences and randomized
// traffic checked against a queue-based reference model of the arbiter and transfer path.
module tb_cdc_xfer_arb;

    localparam int NREQ = 4;
    localparam int DW   = 8;
    localparam int SS   = 2;
`ifdef CDC_XFER_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk1 = 1'b0;
    logic        clk2 = 1'b0;
    logic        rst  = 1'b1;
    logic [3:0]  req_valid = '0;
    logic [31:0] req_data  = '0;
    logic [3:0]  req_ready_o;
    logic        busy_o;
    logic        out_valid_o;
    logic [7:0]  out_data_o;
    logic [1:0]  out_src_o;
    logic [15:0] xfer_cnt_o;

    realtime t2_half = 7.0;

    always #5 clk1 = ~clk1;
    initial forever #(t2_half) clk2 = ~clk2;

    cdc_xfer_arb #(.NREQ(NREQ), .DW(DW), .SYNC_STAGES(SS)) dut (
        .clk1        (clk1),
        .clk2        (clk2),
        .rst         (rst),
        .req_valid_i (req_valid),
        .req_data_i  (req_data),
        .req_ready_o (req_ready_o),
        .busy_o      (busy_o),
        .out_valid_o (out_valid_o),
        .out_data_o  (out_data_o),
        .out_src_o   (out_src_o),
        .xfer_cnt_o  (xfer_cnt_o)
    );

    typedef struct {
        logic [3:0] valid;
        logic [7:0] base;
        logic [3:0] exp_rdy;
        logic [7:0] exp_data;
        logic [1:0] exp_src;
    } vec_t;

    typedef struct {
        logic [7:0] data;
        int         src;
    } exp_t;

    int   tests = 0;
    int   fails = 0;
    int   n_acc = 0;
    int   n_del = 0;
    int   model_rr = 0;
    int   busy_lag = 0;
    int   mon_w;
    logic prev_ov = 1'b0;
    logic [7:0] last_data = '0;
    logic [1:0] last_src  = '0;
    exp_t mon_e, chk_e;
    exp_t exp_q[$];
    int   grant_log[$];
    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int model_pick(input logic [3:0] v, input int ptr);
        for (int k = 0; k < NREQ; k++) begin
            if (v[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
        end
        return -1;
    endfunction

    // Arbiter model: busy bookkeeping, expected grant, and expected-delivery queue.
    always @(negedge clk1) begin
        if (!rst) begin
            if (n_acc != n_del) begin
                check("busy_in_flight", {31'd0, busy_o}, 32'd1);
                busy_lag = 0;
            end else if (busy_o) begin
                busy_lag++;
                check("busy_release_lag", (busy_lag > 4) ? 32'd1 : 32'd0, 32'd0);
            end else begin
                busy_lag = 0;
            end
            if (busy_o) begin
                check("ready_while_busy", {28'd0, req_ready_o}, 32'd0);
            end else begin
                mon_w = model_pick(req_valid, model_rr);
                check("grant", {28'd0, req_ready_o}, (mon_w < 0) ? 32'd0 : (32'd1 << mon_w));
                if (mon_w >= 0) begin
                    mon_e.data = req_data[mon_w*8 +: 8];
                    mon_e.src  = mon_w;
                    exp_q.push_back(mon_e);
                    grant_log.push_back(mon_w);
                    model_rr = (mon_w + 1) % NREQ;
                    n_acc++;
                end
            end
        end
    end

    always @(negedge clk2) begin
        if (rst) begin
            prev_ov = 1'b0;
        end else begin
            if (prev_ov) begin
                check("out_valid_width", {31'd0, out_valid_o}, 32'd0);
            end else if (out_valid_o) begin
                if (exp_q.size() == 0) begin
                    check("spurious_out_valid", {31'd0, out_valid_o}, 32'd0);
                end else begin
                    chk_e = exp_q.pop_front();
                    check("out_data", {24'd0, out_data_o}, {24'd0, chk_e.data});
                    check("out_src", {30'd0, out_src_o}, chk_e.src);
                    last_data = out_data_o;
                    last_src  = out_src_o;
                    n_del++;
                end
            end
            prev_ov = out_valid_o;
        end
    end

    // Caller is positioned just after a clk1 rising edge.
    task automatic apply_reset(input int ncyc);
        rst       = 1'b1;
        req_valid = '0;
        exp_q.delete();
        grant_log.delete();
        model_rr  = 0;
        n_acc     = n_del;
        busy_lag  = 0;
        repeat (ncyc) @(posedge clk1);
        @(negedge clk1);
        check("rst_req_ready", {28'd0, req_ready_o}, 32'd0);
        check("rst_busy", {31'd0, busy_o}, 32'd0);
        check("rst_out_valid", {31'd0, out_valid_o}, 32'd0);
        check("rst_out_data", {24'd0, out_data_o}, 32'd0);
        check("rst_out_src", {30'd0, out_src_o}, 32'd0);
        check("rst_xfer_cnt", {16'd0, xfer_cnt_o}, 32'd0);
        @(posedge clk1);
        #1 rst = 1'b0;
    endtask

    task automatic wait_ready(input string tag);
        int ok = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk1);
            if (req_ready_o != '0) begin
                ok = 1;
                break;
            end
        end
        check({tag, "_grant_seen"}, ok, 1);
    endtask

    task automatic wait_idle(input string tag);
        int ok = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk1);
            if (n_del == n_acc && !busy_o) begin
                ok = 1;
                break;
            end
        end
        check({tag, "_idle"}, ok, 1);
    endtask

    task automatic do_xfer(input vec_t v, input string tag);
        int d0 = n_del;
        @(posedge clk1);
        #1;
        req_valid = v.valid;
        req_data  = {v.base + 8'd3, v.base + 8'd2, v.base + 8'd1, v.base};
        wait_ready(tag);
        check({tag, "_ready"}, {28'd0, req_ready_o}, {28'd0, v.exp_rdy});
        @(posedge clk1);
        #1 req_valid = '0;
        @(negedge clk1);
        check({tag, "_busy_no_ready"}, {27'd0, busy_o, req_ready_o}, 32'h10);
        for (int c = 0; c < 400; c++) begin
            if (n_del != d0) break;
            @(negedge clk1);
        end
        check({tag, "_delivered"}, n_del - d0, 1);
        check({tag, "_data"}, {24'd0, last_data}, {24'd0, v.exp_data});
        check({tag, "_src"}, {30'd0, last_src}, {30'd0, v.exp_src});
        wait_idle(tag);
    endtask

    task automatic run_random(input int n, input string tag);
        int a0 = n_acc;
        int d0 = n_del;
        int ok = 0;
        for (int c = 0; c < 20000; c++) begin
            @(posedge clk1);
            #1;
            if (n_acc - a0 >= n) begin
                ok = 1;
                break;
            end
            req_valid = 4'($urandom_range(0, 15));
            req_data  = $urandom;
        end
        req_valid = '0;
        check({tag, "_accept_budget"}, ok, 1);
        wait_idle(tag);
        check({tag, "_delivered"}, n_del - d0, n);
        check({tag, "_queue_empty"}, exp_q.size(), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, %0d tests run, %0d failed", tests, fails);
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        int nlog;
        vecs[0] = '{4'b0100, 8'hA3, 4'b0100, 8'hA5, 2'd2};
        vecs[1] = '{4'b0011, 8'h10, 4'b0001, 8'h10, 2'd0};
        vecs[2] = '{4'b1111, 8'h20, 4'b0010, 8'h21, 2'd1};
        vecs[3] = '{4'b1001, 8'h30, 4'b1000, 8'h33, 2'd3};
        vecs[4] = '{4'b0010, 8'h40, 4'b0010, 8'h41, 2'd1};
        vecs[5] = '{4'b1011, 8'hF0, 4'b1000, 8'hF3, 2'd3};

        @(posedge clk1);
        #1;
        apply_reset(3);

        for (int i = 0; i < 6; i++) begin
            do_xfer(vecs[i], $sformatf("vec%0d", i));
            check("xfer_cnt", {16'd0, xfer_cnt_o}, STATS ? (i + 1) : 0);
        end

        // Fairness: every requester valid for 8 back-to-back transfers.
        grant_log.delete();
        d0 = n_acc;
        @(posedge clk1);
        #1;
        req_valid = 4'hF;
        req_data  = 32'h53525150;
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk1);
            #1;
            if (n_acc - d0 >= 8) break;
        end
        req_valid = '0;
        wait_idle("fair");
        check("fair_count", grant_log.size(), 8);
        nlog = (grant_log.size() < 8) ? grant_log.size() : 8;
        for (int k = 0; k < nlog; k++) begin
            check($sformatf("fair_order%0d", k), grant_log[k], k % 4);
        end

        // Held data must survive changes on the requester bus during the flight.
        d0 = n_del;
        @(posedge clk1);
        #1;
        req_valid = 4'b0001;
        req_data  = {24'($urandom), 8'h3C};
        wait_ready("stab");
        check("stab_ready", {28'd0, req_ready_o}, 32'd1);
        for (int c = 0; c < 400; c++) begin
            @(posedge clk1);
            #1;
            req_valid      = '0;
            req_data[7:0]  = 8'($urandom);
            if (n_del != d0) break;
        end
        check("stab_delivered", n_del - d0, 1);
        check("stab_data", {24'd0, last_data}, 32'h3C);
        wait_idle("stab");

        // Reset one clk1 cycle after acceptance discards the transfer.
        d0 = n_del;
        @(posedge clk1);
        #1;
        req_valid = 4'b0100;
        req_data  = 32'h73727170;
        wait_ready("midrst");
        check("midrst_ready", {28'd0, req_ready_o}, 32'h4);
        @(posedge clk1);
        #1 req_valid = '0;
        @(posedge clk1);
        #1;
        apply_reset(5);
        repeat (30) @(negedge clk1);
        check("midrst_no_delivery", n_del - d0, 0);
        do_xfer('{4'b1001, 8'h60, 4'b0001, 8'h60, 2'd0}, "post_rst");
        check("post_rst_xfer_cnt", {16'd0, xfer_cnt_o}, STATS ? 1 : 0);

        run_random(20, "rand_t2_14");
        t2_half = 2.0;
        run_random(20, "rand_t2_4");
        t2_half = 20.0;
        run_random(20, "rand_t2_40");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
